// File: rtl/kbd_pkg.sv
// Shared types and PS/2 byte constants for the key event decoder.
// Holds the decoder state encoding and the decoded key event record.
package kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kbd_state_e;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
   localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
   localparam logic [7:0] PS2_NULL       = 8'h00;
   localparam logic [7:0] PS2_OVERRUN    = 8'hFF;

   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } key_event_t;

   // Keyboard status bytes that carry no key information when seen between events.
   function automatic logic is_status_byte(input logic [7:0] b);
      return (b == PS2_BAT_OK) || (b == PS2_NULL) || (b == PS2_OVERRUN);
   endfunction

endpackage

// File: rtl/prefix_timer.sv
// Saturating cycle counter that flags when a prefix has waited too long
// for its follow-on byte.
module prefix_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Stops at LAST so a long stall can never wrap back into a false window.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/key_event_decoder.sv
// PS/2 set-2 byte stream to key make/break event decoder with repeat
// suppression, held-key tracking and a short history of pressed keys.
module key_event_decoder
   import kbd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_scan_code,
   input  logic [7:0]  scan_code_out,
   output logic        key_valid,
   output logic [7:0]  key_code,
   output logic        key_ext,
   output logic        key_release,
   output logic [31:0] key_hist,
   output logic        held_valid,
   output logic [8:0]  held_code,
   output logic        proto_err,
   output kbd_state_e  dbg_state_o
);

   kbd_state_e state_q;
   kbd_state_e state_d;

   logic       tmo_expired;
   logic       byte_is_ext;
   logic       byte_is_brk;

   logic       ev_make;
   logic       ev_brk;
   logic       ev_err;
   key_event_t ev;

   logic        key_valid_q,   key_valid_d;
   logic [7:0]  key_code_q,    key_code_d;
   logic        key_ext_q,     key_ext_d;
   logic        key_release_q, key_release_d;
   logic [31:0] key_hist_q,    key_hist_d;
   logic        held_valid_q,  held_valid_d;
   logic [8:0]  held_code_q,   held_code_d;
   logic        proto_err_q,   proto_err_d;
   logic        held_match;

   assign byte_is_ext = (scan_code_out == PS2_PREFIX_EXT);
   assign byte_is_brk = (scan_code_out == PS2_PREFIX_BRK);

   // Any accepted byte restarts the window, so every prefix state is entered with a fresh count.
   prefix_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_prefix_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (valid_scan_code),
      .enable  (state_q != ST_IDLE),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (valid_scan_code) begin
               if (byte_is_ext)      state_d = ST_EXT;
               else if (byte_is_brk) state_d = ST_BRK;
            end
         end
         ST_EXT: begin
            if (valid_scan_code) begin
               state_d = byte_is_brk ? ST_EXT_BRK : ST_IDLE;
            end else if (tmo_expired) begin
               state_d = ST_IDLE;
            end
         end
         ST_BRK, ST_EXT_BRK: begin
            if (valid_scan_code || tmo_expired) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A byte on the expiry cycle is decoded; the timeout only fires on an empty cycle.
   always_comb begin
      ev_make = 1'b0;
      ev_brk  = 1'b0;
      ev_err  = 1'b0;
      ev      = '{ext: 1'b0, rel: 1'b0, code: scan_code_out};
      unique case (state_q)
         ST_IDLE: begin
            if (valid_scan_code && !byte_is_ext && !byte_is_brk &&
                !is_status_byte(scan_code_out)) begin
               ev_make = 1'b1;
            end
         end
         ST_EXT: begin
            if (valid_scan_code) begin
               if (byte_is_ext) begin
                  ev_err = 1'b1;
               end else if (!byte_is_brk) begin
                  ev_make = 1'b1;
                  ev.ext  = 1'b1;
               end
            end else if (tmo_expired) begin
               ev_err = 1'b1;
            end
         end
         ST_BRK, ST_EXT_BRK: begin
            if (valid_scan_code) begin
               if (byte_is_ext || byte_is_brk) begin
                  ev_err = 1'b1;
               end else begin
                  ev_brk = 1'b1;
                  ev.rel = 1'b1;
                  ev.ext = (state_q == ST_EXT_BRK);
               end
            end else if (tmo_expired) begin
               ev_err = 1'b1;
            end
         end
         default: ev_err = 1'b0;
      endcase
   end

   assign held_match = held_valid_q && (held_code_q == {ev.ext, ev.code});

   always_comb begin
      key_valid_d   = 1'b0;
      key_code_d    = key_code_q;
      key_ext_d     = key_ext_q;
      key_release_d = key_release_q;
      key_hist_d    = key_hist_q;
      held_valid_d  = held_valid_q;
      held_code_d   = held_code_q;
      proto_err_d   = ev_err;
      // Typematic repeats of the held key are swallowed entirely.
      if (ev_make && !held_match) begin
         key_valid_d   = 1'b1;
         key_code_d    = ev.code;
         key_ext_d     = ev.ext;
         key_release_d = 1'b0;
         key_hist_d    = {key_hist_q[23:0], ev.code};
         held_valid_d  = 1'b1;
         held_code_d   = {ev.ext, ev.code};
      end
      if (ev_brk) begin
         key_valid_d   = 1'b1;
         key_code_d    = ev.code;
         key_ext_d     = ev.ext;
         key_release_d = 1'b1;
         if (held_match) held_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_valid_q   <= 1'b0;
         key_code_q    <= 8'h00;
         key_ext_q     <= 1'b0;
         key_release_q <= 1'b0;
         key_hist_q    <= 32'h0;
         held_valid_q  <= 1'b0;
         held_code_q   <= 9'h000;
         proto_err_q   <= 1'b0;
      end else begin
         key_valid_q   <= key_valid_d;
         key_code_q    <= key_code_d;
         key_ext_q     <= key_ext_d;
         key_release_q <= key_release_d;
         key_hist_q    <= key_hist_d;
         held_valid_q  <= held_valid_d;
         held_code_q   <= held_code_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign key_ext     = key_ext_q;
   assign key_release = key_release_q;
   assign key_hist    = key_hist_q;
   assign held_valid  = held_valid_q;
   assign held_code   = held_code_q;
   assign proto_err   = proto_err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: byte sequences with hand-computed
// events pushed into an expected queue and checked as they appear.
module tb_key_event_decoder;
   import kbd_pkg::*;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_scan_code = 1'b0;
   logic [7:0]  scan_code_out = 8'h00;
   logic        key_valid;
   logic [7:0]  key_code;
   logic        key_ext;
   logic        key_release;
   logic [31:0] key_hist;
   logic        held_valid;
   logic [8:0]  held_code;
   logic        proto_err;
   kbd_state_e  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int ev_cnt   = 0;
   int err_cnt  = 0;
   int ev_base;
   int err_base;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   key_event_decoder #(
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_scan_code (valid_scan_code),
      .scan_code_out   (scan_code_out),
      .key_valid       (key_valid),
      .key_code        (key_code),
      .key_ext         (key_ext),
      .key_release     (key_release),
      .key_hist        (key_hist),
      .held_valid      (held_valid),
      .held_code       (held_code),
      .proto_err       (proto_err),
      .dbg_state_o     (dbg_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_ev(input logic rel, input logic ext, input logic [7:0] c);
      exp_q.push_back({rel, ext, c});
   endtask

   // Byte held for one cycle; returns at the negedge where its result is visible.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      valid_scan_code = 1'b1;
      scan_code_out   = b;
      @(negedge clk);
      valid_scan_code = 1'b0;
      scan_code_out   = 8'($urandom_range(0, 255));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Scoreboard: every key_valid pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (proto_err === 1'b1) err_cnt++;
      if (key_valid === 1'b1) begin
         ev_cnt++;
         if (exp_q.size() == 0) check_eq("unexpected_event", 32'(exp_q.size()), 32'd1);
         else check_eq("event", {22'd0, key_release, key_ext, key_code}, {22'd0, exp_q.pop_front()});
      end
   end

   initial begin
      // Reset state
      idle(2);
      check_eq("rst_key_valid", key_valid, 0);
      check_eq("rst_key_code", key_code, 0);
      check_eq("rst_key_ext", key_ext, 0);
      check_eq("rst_key_release", key_release, 0);
      check_eq("rst_key_hist", key_hist, 0);
      check_eq("rst_held_valid", held_valid, 0);
      check_eq("rst_held_code", held_code, 0);
      check_eq("rst_proto_err", proto_err, 0);
      check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b1;

      // Single make of 1C
      push_ev(1'b0, 1'b0, 8'h1C);
      send_byte(8'h1C);
      check_eq("mk_valid", key_valid, 1);
      check_eq("mk_code", key_code, 32'h1C);
      check_eq("mk_ext", key_ext, 0);
      check_eq("mk_rel", key_release, 0);
      check_eq("mk_hist", key_hist[7:0], 32'h1C);
      check_eq("mk_held_code", held_code, 32'h01C);
      check_eq("mk_held_valid", held_valid, 1);
      idle(1);
      check_eq("mk_pulse_width", key_valid, 0);
      check_eq("mk_code_hold", key_code, 32'h1C);

      // Typematic repeats, then release
      do_reset();
      ev_base = ev_cnt;
      push_ev(1'b0, 1'b0, 8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      push_ev(1'b1, 1'b0, 8'h1C);
      send_byte(8'hF0);
      send_byte(8'h1C);
      idle(2);
      check_eq("rep_event_count", 32'(ev_cnt - ev_base), 2);
      check_eq("rep_held_valid", held_valid, 0);
      check_eq("rep_release_hold", key_release, 1);
      check_eq("rep_hist", key_hist, 32'h0000001C);

      // Break of a key that is not the held one
      push_ev(1'b0, 1'b0, 8'h1C);
      send_byte(8'h1C);
      push_ev(1'b1, 1'b0, 8'h2D);
      send_byte(8'hF0);
      send_byte(8'h2D);
      check_eq("nm_brk_valid", key_valid, 1);
      check_eq("nm_brk_held_valid", held_valid, 1);
      check_eq("nm_brk_held_code", held_code, 32'h01C);

      // Extended make and break
      do_reset();
      push_ev(1'b0, 1'b1, 8'h75);
      send_byte(8'hE0);
      send_byte(8'h75);
      check_eq("ext_mk_ext", key_ext, 1);
      check_eq("ext_mk_held_code", held_code, 32'h175);
      push_ev(1'b1, 1'b1, 8'h75);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      check_eq("ext_brk_ext", key_ext, 1);
      check_eq("ext_brk_rel", key_release, 1);
      check_eq("ext_hist", key_hist[7:0], 32'h75);
      check_eq("ext_brk_held_valid", held_valid, 0);

      // Status bytes in IDLE are dropped
      idle(1);
      ev_base  = ev_cnt;
      err_base = err_cnt;
      send_byte(8'hAA);
      send_byte(8'h00);
      send_byte(8'hFF);
      idle(2);
      check_eq("drop_events", 32'(ev_cnt - ev_base), 0);
      check_eq("drop_errs", 32'(err_cnt - err_base), 0);

      // Double break prefix is a protocol error
      send_byte(8'hF0);
      send_byte(8'hF0);
      check_eq("ff_proto_err", proto_err, 1);
      check_eq("ff_state", 32'(dbg_state), 32'(ST_IDLE));
      push_ev(1'b0, 1'b0, 8'h32);
      send_byte(8'h32);
      check_eq("ff_next_code", key_code, 32'h32);
      check_eq("ff_next_err", proto_err, 0);

      // Timeout after a lone E0
      idle(2);
      err_base = err_cnt;
      send_byte(8'hE0);
      idle(15);
      check_eq("tmo_pre_err", proto_err, 0);
      check_eq("tmo_pre_state", 32'(dbg_state), 32'(ST_EXT));
      idle(1);
      check_eq("tmo_err", proto_err, 1);
      check_eq("tmo_state", 32'(dbg_state), 32'(ST_IDLE));

      // Byte landing on the expiry cycle wins
      send_byte(8'hE0);
      idle(14);
      check_eq("race_state", 32'(dbg_state), 32'(ST_EXT));
      push_ev(1'b0, 1'b1, 8'h74);
      send_byte(8'h74);
      check_eq("race_valid", key_valid, 1);
      check_eq("race_ext", key_ext, 1);
      check_eq("race_code", key_code, 32'h74);
      check_eq("race_err", proto_err, 0);
      idle(2);
      check_eq("race_err_count", 32'(err_cnt - err_base), 1);

      // History of five makes, then reset in the middle of a break prefix
      do_reset();
      push_ev(1'b0, 1'b0, 8'h15); send_byte(8'h15);
      push_ev(1'b0, 1'b0, 8'h1D); send_byte(8'h1D);
      push_ev(1'b0, 1'b0, 8'h24); send_byte(8'h24);
      push_ev(1'b0, 1'b0, 8'h2D); send_byte(8'h2D);
      push_ev(1'b0, 1'b0, 8'h2C); send_byte(8'h2C);
      check_eq("hist_full", key_hist, 32'h1D242D2C);
      send_byte(8'hF0);
      check_eq("mid_state", 32'(dbg_state), 32'(ST_BRK));
      idle(1);
      ev_base  = ev_cnt;
      err_base = err_cnt;
      #2 rst = 1'b0;
      #1;
      check_eq("arst_key_code", key_code, 0);
      check_eq("arst_key_hist", key_hist, 0);
      check_eq("arst_held_valid", held_valid, 0);
      check_eq("arst_held_code", held_code, 0);
      check_eq("arst_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b1;
      idle(5);
      check_eq("post_rst_events", 32'(ev_cnt - ev_base), 0);
      check_eq("post_rst_errs", 32'(err_cnt - err_base), 0);
      check_eq("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("exp_q_drained", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1_000_000, SHALL set the cycles allowed between a prefix byte and its following byte.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 valid_scan_code  input  1  SHALL be a one-cycle strobe marking a new byte on scan_code_out.
REQ-005 scan_code_out  input  8  SHALL be the received PS/2 byte, sampled only when valid_scan_code=1.
REQ-006 key_valid  output  1  SHALL be a one-cycle pulse marking a decoded key event.
REQ-007 key_code  output  8  SHALL be the event's key byte, with prefixes stripped.
REQ-008 key_ext  output  1  SHALL be 1 when the event was E0-prefixed.
REQ-009 key_release  output  1  SHALL be 1 for a break event and 0 for a make event.
REQ-010 key_hist  output  32  SHALL hold the last four non-repeat make codes, newest in [7:0] and oldest in [31:24].
REQ-011 held_valid  output  1  SHALL be 1 while a key is held.
REQ-012 held_code  output  9  SHALL hold {ext, code} of the held key.
REQ-013 proto_err  output  1  SHALL be a one-cycle pulse on a protocol violation or a timeout.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, EXT, BRK and EXT_BRK.
REQ-015 In IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make event with ext=0, staying in IDLE.
REQ-016 In EXT: F0 -> EXT_BRK; E0 -> proto_err and return to IDLE; any other byte -> make event with ext=1, then IDLE.
REQ-017 In BRK: E0 or F0 -> proto_err and return to IDLE; any other byte -> break event with ext=0, then IDLE.
REQ-018 In EXT_BRK: E0 or F0 -> proto_err and return to IDLE; any other byte -> break event with ext=1, then IDLE.
REQ-019 key_valid, key_code, key_ext and key_release SHALL be registered and valid exactly one clock after the valid_scan_code cycle.
REQ-020 key_code, key_ext and key_release SHALL hold their values until the next event.
REQ-021 Repeat suppression: a make event whose {ext,code} equals held_code while held_valid=1 SHALL NOT pulse key_valid and SHALL NOT shift key_hist.
REQ-022 A non-repeat make event SHALL load held_code, set held_valid, and shift key_hist left by 8 with the new code inserted at [7:0].
REQ-023 A break event matching held_code SHALL clear held_valid.
REQ-024 A non-matching break event SHALL pulse key_valid and leave held_code and held_valid unchanged.
REQ-025 Timeout counter behaviour:
- SHALL clear on entry to EXT, BRK or EXT_BRK;
- SHALL increment every cycle in those states;
- on reaching TIMEOUT_CYCLES-1 with no byte, SHALL force IDLE and pulse proto_err.
REQ-026 A byte arriving in the same cycle as timeout expiry SHALL win: it is decoded normally and proto_err SHALL NOT pulse.
REQ-027 The counter SHALL saturate and never wrap.
REQ-028 Bytes 0xAA, 0x00 and 0xFF received in IDLE SHALL be dropped: no event, no proto_err.

Reset
REQ-029 On rst=0, the block SHALL asynchronously enter IDLE and drive to zero: key_valid, key_code, key_ext, key_release, key_hist, held_valid, held_code, proto_err and the timeout counter.
REQ-030 Reset asserted mid-prefix SHALL discard the pending prefix and SHALL NOT emit any event after release.

Structure
REQ-031 Package kbd_pkg SHALL hold:
- the state enum;
- constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, PS2_BAT_OK=8'hAA;
- the key event struct {ext, release, code}.
REQ-032 The timeout counter SHALL be a separate sub-module, prefix_timer, with inputs clear and enable and output expired.

Verification
REQ-033 Byte 1C -> one cycle later: key_valid=1, key_code=1C, ext=0, rel=0; key_hist[7:0]=1C; held_code=0_1C.
REQ-034 Bytes 1C,1C,1C then F0,1C -> exactly two key_valid pulses (make, then break with rel=1); held_valid=0 at the end.
REQ-035 Bytes E0,75 then E0,F0,75 -> make and break events, both with ext=1 and key_code=75; key_hist[7:0]=75.
REQ-036 Bytes F0,F0 -> proto_err pulse, FSM in IDLE; a following byte 32 decodes as a make event.
REQ-037 With TIMEOUT_CYCLES=16: byte E0, then 16 idle cycles -> proto_err pulse and return to IDLE; byte E0 with 74 arriving on the expiry cycle -> make event with ext=1 and no proto_err.
REQ-038 Makes 15,1D,24,2D,2C -> key_hist=1D242D2C; rst pulsed after a lone F0 -> all outputs 0 and no event after release.
